// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and sequencing controller for the 5-stage RV32 pipeline.
// Operand forwarding, load-use and taken-branch hazards are resolved
// combinationally. A small FSM sequences data-memory wait states (M stage)
// and iterative mul/div occupancy (E stage).
// Stall/flush outputs react within the same cycle as the hazard, so they are
// decoded from the registered state plus the current inputs. MemErr is registered.

module pipeline_ctrl #(
    parameter int MULDIV_LATENCY = 4,
    parameter int MEM_TIMEOUT    = 255,
    parameter int CNT_WIDTH      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       LoadE,
    input  logic       PCSrcE,
    input  logic       MulDivE,
    input  logic       MemReqM,
    input  logic       MemReadyM,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic       FlushW,
    output logic       MulDivDoneE,
    output logic       MemErr
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        MULDIV  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] DIV_LOAD  = CNT_WIDTH'(MULDIV_LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0] MEM_LIMIT = CNT_WIDTH'(MEM_TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    state_t               state;
    logic [CNT_WIDTH-1:0] memcnt;
    logic [CNT_WIDTH-1:0] divcnt;
    logic                 mem_err;
    logic                 load_use;
    logic                 mem_wait;

    // M result has priority over W because it is the younger write; x0 never forwards
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       wr_m,
        input logic [4:0] rd_m,
        input logic       wr_w,
        input logic [4:0] rd_w
    );
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return 2'b10;
        end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    // Hazard detection terms shared by the output decode and the FSM
    always_comb begin
        load_use = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
        mem_wait = MemReqM && !MemReadyM;
    end

    // Output decode: reset drains the pipeline, otherwise the state picks the stall/flush pattern
    always_comb begin
        ForwardAE   = 2'b00;
        ForwardBE   = 2'b00;
        StallF      = 1'b0;
        StallD      = 1'b0;
        StallE      = 1'b0;
        StallM      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        FlushM      = 1'b0;
        FlushW      = 1'b0;
        MulDivDoneE = 1'b0;
        if (!rst_n) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
            FlushW = 1'b1;
        end else begin
            ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
            ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
            unique case (state)
                RUN: begin
                    if (mem_wait) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        StallE = 1'b1;
                        StallM = 1'b1;
                        FlushW = 1'b1;
                    end else if (MulDivE) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        StallE = 1'b1;
                        FlushM = 1'b1;
                    end else begin
                        FlushD = PCSrcE;
                        FlushE = PCSrcE || load_use;
                        StallF = load_use && !PCSrcE;
                        StallD = load_use && !PCSrcE;
                    end
                end
                MEMWAIT: begin
                    if (!MemReadyM) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        StallE = 1'b1;
                        StallM = 1'b1;
                        FlushW = 1'b1;
                    end else begin
                        // A branch resolved while E was frozen is acted on as the pipeline moves
                        FlushD = PCSrcE;
                        FlushE = PCSrcE || load_use;
                        StallF = load_use && !PCSrcE;
                        StallD = load_use && !PCSrcE;
                    end
                end
                MULDIV: begin
                    if (divcnt != '0) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        StallE = 1'b1;
                        FlushM = 1'b1;
                    end else begin
                        MulDivDoneE = 1'b1;
                        FlushD      = PCSrcE;
                        FlushE      = PCSrcE || load_use;
                    end
                end
                default: begin
                    FlushD = PCSrcE;
                    FlushE = PCSrcE || load_use;
                end
            endcase
        end
        MemErr = mem_err;
    end

    // Sequencer: tracks memory wait length and mul/div occupancy, raises the sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            memcnt  <= '0;
            divcnt  <= '0;
            mem_err <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (mem_wait) begin
                        memcnt <= CNT_ONE;
                        if (MEM_LIMIT <= CNT_ONE) begin
                            mem_err <= 1'b1;
                        end
                        state <= MEMWAIT;
                    end else if (MulDivE) begin
                        divcnt <= DIV_LOAD;
                        state  <= MULDIV;
                    end
                end
                MEMWAIT: begin
                    if (MemReadyM) begin
                        memcnt <= '0;
                        state  <= RUN;
                    end else begin
                        if (memcnt < MEM_LIMIT) begin
                            memcnt <= memcnt + CNT_ONE;
                        end
                        if (memcnt >= (MEM_LIMIT - CNT_ONE)) begin
                            mem_err <= 1'b1;
                        end
                    end
                end
                MULDIV: begin
                    if (divcnt != '0) begin
                        divcnt <= divcnt - CNT_ONE;
                    end else begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed bench for pipeline_ctrl (MULDIV_LATENCY=4, MEM_TIMEOUT=2).
// Each step pushes the expected output vector to a scoreboard queue; the
// vector is popped and compared at the following falling clock edge.

module tb_pipeline_ctrl;

    typedef struct {
        string       tag;
        logic [13:0] val;
    } exp_t;

    localparam logic [3:0] S_NONE = 4'b0000;
    localparam logic [3:0] S_FD   = 4'b1100;
    localparam logic [3:0] S_FDE  = 4'b1110;
    localparam logic [3:0] S_ALL  = 4'b1111;
    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_ALL  = 4'b1111;
    localparam logic [3:0] F_E    = 4'b0100;
    localparam logic [3:0] F_DE   = 4'b1100;
    localparam logic [3:0] F_M    = 4'b0010;
    localparam logic [3:0] F_W    = 4'b0001;

    logic       clk;
    logic       rst_n;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW, LoadE, PCSrcE, MulDivE, MemReqM, MemReadyM;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM;
    logic       FlushD, FlushE, FlushM, FlushW;
    logic       MulDivDoneE, MemErr;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    pipeline_ctrl #(
        .MULDIV_LATENCY(4),
        .MEM_TIMEOUT   (2),
        .CNT_WIDTH     (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .RdM        (RdM),
        .RdW        (RdW),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .LoadE      (LoadE),
        .PCSrcE     (PCSrcE),
        .MulDivE    (MulDivE),
        .MemReqM    (MemReqM),
        .MemReadyM  (MemReadyM),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .StallM     (StallM),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .FlushM     (FlushM),
        .FlushW     (FlushW),
        .MulDivDoneE(MulDivDoneE),
        .MemErr     (MemErr)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Pack an expected output vector: {FA, FB, StallF/D/E/M, FlushD/E/M/W, Done, Err}
    function automatic logic [13:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                       input logic [3:0] st, input logic [3:0] fl,
                                       input logic done, input logic err);
        return {fa, fb, st, fl, done, err};
    endfunction

    function automatic logic [13:0] observed();
        return {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                FlushD, FlushE, FlushM, FlushW, MulDivDoneE, MemErr};
    endfunction

    task automatic setIdle();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; LoadE = 1'b0; PCSrcE = 1'b0;
        MulDivE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
    endtask

    task automatic applyStimulus(input string tag, input logic [13:0] e);
        exp_t item;
        item.tag = tag;
        item.val = e;
        sb.push_back(item);
    endtask

    task automatic checkOutput();
        exp_t        item;
        logic [13:0] obs;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("[TB] FAIL scoreboard observed=empty expected=entry");
        end else begin
            item = sb.pop_front();
            obs  = observed();
            assert (obs === item.val) else begin
                bad++;
                $error("[TB] FAIL %s observed=%b expected=%b", item.tag, obs, item.val);
            end
        end
    endtask

    // One clock: expect e during this cycle, check at the falling edge, return at rise+1
    task automatic step(input string tag, input logic [13:0] e);
        applyStimulus(tag, e);
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    initial begin
        setIdle();
        rst_n = 1'b0;
        LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
        RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5;
        for (int i = 0; i < 3; i++) begin
            step("reset_hold", mk(2'b00, 2'b00, S_NONE, F_ALL, 1'b0, 1'b0));
        end

        rst_n = 1'b1;
        setIdle();
        step("post_reset_idle", mk(2'b00, 2'b00, S_NONE, F_NONE, 1'b0, 1'b0));

        Rs1E = 5'd5; RdM = 5'd5; RdW = 5'd5; RegWriteM = 1'b1; RegWriteW = 1'b1; Rs2E = 5'd6;
        step("fwd_m_priority", mk(2'b10, 2'b00, S_NONE, F_NONE, 1'b0, 1'b0));
        RegWriteM = 1'b0;
        step("fwd_w_only", mk(2'b01, 2'b00, S_NONE, F_NONE, 1'b0, 1'b0));
        Rs1E = 5'd0; RdM = 5'd0; RdW = 5'd0; RegWriteM = 1'b1;
        step("fwd_x0", mk(2'b00, 2'b00, S_NONE, F_NONE, 1'b0, 1'b0));
        Rs1E = 5'd4; RdM = 5'd4; Rs2E = 5'd3; RdW = 5'd3;
        step("fwd_a_m_b_w", mk(2'b10, 2'b01, S_NONE, F_NONE, 1'b0, 1'b0));

        setIdle();
        LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
        step("load_use", mk(2'b00, 2'b00, S_FD, F_E, 1'b0, 1'b0));
        setIdle();
        step("load_use_one_cycle", mk(2'b00, 2'b00, S_NONE, F_NONE, 1'b0, 1'b0));
        LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7; PCSrcE = 1'b1;
        step("load_use_branch", mk(2'b00, 2'b00, S_NONE, F_DE, 1'b0, 1'b0));
        setIdle();
        LoadE = 1'b1;
        step("load_x0", mk(2'b00, 2'b00, S_NONE, F_NONE, 1'b0, 1'b0));
        setIdle();
        PCSrcE = 1'b1;
        step("branch_only", mk(2'b00, 2'b00, S_NONE, F_DE, 1'b0, 1'b0));

        setIdle();
        MulDivE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            MemReqM   = (i == 1);
            MemReadyM = 1'b0;
            step("muldiv_stall", mk(2'b00, 2'b00, S_FDE, F_M, 1'b0, 1'b0));
        end
        MemReqM = 1'b0;
        step("muldiv_done", mk(2'b00, 2'b00, S_NONE, F_NONE, 1'b1, 1'b0));
        MulDivE = 1'b0;
        step("muldiv_after", mk(2'b00, 2'b00, S_NONE, F_NONE, 1'b0, 1'b0));

        MemReqM = 1'b1; MemReadyM = 1'b0;
        step("memwait_1", mk(2'b00, 2'b00, S_ALL, F_W, 1'b0, 1'b0));
        PCSrcE = 1'b1; MulDivE = 1'b1;
        step("memwait_2_prio", mk(2'b00, 2'b00, S_ALL, F_W, 1'b0, 1'b0));
        PCSrcE = 1'b0; MulDivE = 1'b0;
        step("memwait_3_err", mk(2'b00, 2'b00, S_ALL, F_W, 1'b0, 1'b1));
        MemReadyM = 1'b1;
        step("mem_release", mk(2'b00, 2'b00, S_NONE, F_NONE, 1'b0, 1'b1));
        setIdle();
        step("memerr_sticky", mk(2'b00, 2'b00, S_NONE, F_NONE, 1'b0, 1'b1));

        rst_n = 1'b0;
        step("reset_clears_err", mk(2'b00, 2'b00, S_NONE, F_ALL, 1'b0, 1'b0));
        rst_n = 1'b1;
        step("idle_after_reset", mk(2'b00, 2'b00, S_NONE, F_NONE, 1'b0, 1'b0));

        MemReqM = 1'b1; MemReadyM = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step("timeout_wait", mk(2'b00, 2'b00, S_ALL, F_W, 1'b0, (i >= 2)));
        end
        MemReadyM = 1'b1;
        step("timeout_release", mk(2'b00, 2'b00, S_NONE, F_NONE, 1'b0, 1'b1));
        setIdle();
        for (int i = 0; i < 2; i++) begin
            step("timeout_sticky", mk(2'b00, 2'b00, S_NONE, F_NONE, 1'b0, 1'b1));
        end

        rst_n = 1'b0;
        step("reset_again", mk(2'b00, 2'b00, S_NONE, F_ALL, 1'b0, 1'b0));
        rst_n = 1'b1;
        step("idle_again", mk(2'b00, 2'b00, S_NONE, F_NONE, 1'b0, 1'b0));

        MulDivE = 1'b1;
        step("abort_c0", mk(2'b00, 2'b00, S_FDE, F_M, 1'b0, 1'b0));
        step("abort_c1", mk(2'b00, 2'b00, S_FDE, F_M, 1'b0, 1'b0));
        applyStimulus("abort_c2_pre", mk(2'b00, 2'b00, S_FDE, F_M, 1'b0, 1'b0));
        checkOutput();
        #1;
        rst_n = 1'b0;
        #1;
        applyStimulus("abort_async", mk(2'b00, 2'b00, S_NONE, F_ALL, 1'b0, 1'b0));
        checkOutput();
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        MulDivE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("abort_no_done", mk(2'b00, 2'b00, S_NONE, F_NONE, 1'b0, 1'b0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage RV32 pipeline.
- Drives stall and flush enables of the F/D, D/E, E/M and M/W pipeline registers, and the E-stage forwarding muxes.
- Resolves load-use and taken-branch hazards combinationally.
- Sequences two multi-cycle events with an FSM: data-memory wait states (M stage) and iterative mul/div occupancy (E stage).

Parameters:
- MULDIV_LATENCY, 4: cycles a mul/div op keeps the pipeline stalled; must be >= 2.
- MEM_TIMEOUT, 255: max consecutive memory wait cycles before MemErr is raised; must be >= 1.
- CNT_WIDTH, 8: width of the internal counters; must hold max(MULDIV_LATENCY, MEM_TIMEOUT).

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- Rs1D, Rs2D  in  5  source registers of the instruction in D.
- Rs1E, Rs2E, RdE  in  5  source and destination registers in E.
- RdM, RdW  in  5  destination registers in M and W.
- RegWriteM, RegWriteW  in  1  register-file write enables in M and W.
- LoadE  in  1  instruction in E is a load.
- PCSrcE  in  1  taken branch or jump resolved in E.
- MulDivE  in  1  instruction in E is a multi-cycle mul/div.
- MemReqM  in  1  instruction in M accesses data memory.
- MemReadyM  in  1  data memory completes the access this cycle.
- ForwardAE, ForwardBE  out  2  E operand select: 00 = regfile, 01 = W result, 10 = M ALU result.
- StallF, StallD, StallE, StallM  out  1  hold the PC / respective pipeline register.
- FlushD, FlushE, FlushM, FlushW  out  1  load NOP/bubble into the respective register.
- MulDivDoneE  out  1  1-cycle pulse: mul/div result valid, E advances at this edge.
- MemErr  out  1  sticky: memory wait exceeded MEM_TIMEOUT.

Behaviour:
- Reset (rst_n low, async):
  - state=RUN, counters=0, MemErr=0.
  - All stalls 0, forwards 00, MulDivDoneE 0.
  - FlushD=FlushE=FlushM=FlushW=1 while rst_n low, so reset drains the pipeline to NOPs.
  - Release is effective on the first clk edge after rst_n rises.
- Forwarding, combinational, per operand (shown for A; B identical with Rs2E):
  - 10 if RegWriteM and RdM!=0 and RdM==Rs1E.
  - else 01 if RegWriteW and RdW!=0 and RdW==Rs1E.
  - else 00.
  - M has priority over W. x0 never forwards.
- lwStall = LoadE and RdE!=0 and (RdE==Rs1D or RdE==Rs2D).
- FSM states: RUN, MEMWAIT, MULDIV. Priority within a cycle: memory wait > mul/div > PCSrcE > lwStall.
- RUN:
  - If MemReqM and !MemReadyM:
    - Assert StallF/D/E/M and FlushW this same cycle.
    - Force FlushD/E/M=0; set memcnt=1; go to MEMWAIT.
  - Else if MulDivE:
    - Assert StallF/D/E and FlushM; force FlushD/E=0.
    - Load divcnt=MULDIV_LATENCY-1; go to MULDIV.
  - Else normal operation:
    - FlushD=PCSrcE.
    - FlushE=PCSrcE or lwStall.
    - StallF=StallD=lwStall and !PCSrcE.
    - StallE=StallM=FlushM=FlushW=0.
- MEMWAIT:
  - While !MemReadyM: hold StallF/D/E/M=1, FlushW=1, FlushD/E/M=0; memcnt increments, saturating.
  - When memcnt reaches MEM_TIMEOUT with !MemReadyM, set MemErr=1. It stays set until reset, and stalling continues.
  - When MemReadyM=1: drop all stalls that cycle (pipeline advances at the edge) and return to RUN.
  - A deferred MulDivE is handled in RUN on the next cycle.
- MULDIV:
  - While divcnt>0: StallF/D/E=1, FlushM=1, other flushes 0, divcnt decrements.
  - When divcnt==0: no stalls, MulDivDoneE=1, FlushD/E per PCSrcE/lwStall rules; return to RUN.
  - Total stalled cycles = MULDIV_LATENCY; the op occupies E for MULDIV_LATENCY+1 cycles.
- M holds bubbles during MULDIV, so MemReqM is ignored in MULDIV.
- Reset asserted in MEMWAIT or MULDIV aborts immediately to RUN with reset output values. No done pulse is emitted.
- An output is never both stall=1 and flush=1 for the same register, except under reset.

Test Plan:
- Reset hold: rst_n=0 for 3 cycles with LoadE=1 and a matching RdE -> all flushes 1, stalls 0; after release with no hazards, all outputs 0.
- Forward priority: RdM=RdW=Rs1E=5, RegWriteM=RegWriteW=1 -> ForwardAE=10. With RegWriteM=0 -> 01. With Rs1E=RdM=RdW=0 -> 00.
- Load-use: LoadE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for exactly 1 cycle. Adding PCSrcE=1 in the same cycle -> FlushD=FlushE=1, StallF=StallD=0.
- Mul/div, MULDIV_LATENCY=4: MulDivE held -> StallE=1 for cycles 0-3, MulDivDoneE=1 in cycle 4, FlushM=1 in cycles 0-3.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles then 1 -> StallM=FlushW=1 for 3 cycles, released in the 4th. With MEM_TIMEOUT=2 and 5 wait cycles -> MemErr rises after the 2nd wait cycle and stays high.
- Async abort: drop rst_n mid-MULDIV (divcnt=2), asynchronously -> stalls clear immediately without waiting for clk; after release state is RUN and no MulDivDoneE pulse.
